// File: rtl/pipeline_fetch_unit.sv
// Instruction fetch stage: PC-sequential reads of a 1-cycle-latency imem into a 2-entry queue.
// Fetch-to-valid latency 2 cycles; stalls hold the head and stop issue once 2 words are held.
module pipeline_fetch_unit #(
  parameter logic [15:0] NOP_IR   = 16'h0000,
  parameter logic [7:0]  RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  imem_addr,
  output logic        imem_rd,
  input  logic [15:0] imem_rdata,
  input  logic        accept_in,
  input  logic        redirect_in,
  input  logic [7:0]  redirect_pc,
  output logic [15:0] IR_out,
  output logic [7:0]  PC_out,
  output logic        valid_out
);

  typedef enum logic [1:0] {
    S_RESET  = 2'd0,
    S_RUN    = 2'd1,
    S_REFILL = 2'd2
  } state_t;

  state_t      r_state;
  logic [7:0]  r_fetch_pc;
  logic [15:0] r_q_ir0;
  logic [15:0] r_q_ir1;
  logic [7:0]  r_q_pc0;
  logic [7:0]  r_q_pc1;
  logic [1:0]  r_count;
  logic        r_inflight;
  logic [7:0]  r_inflight_pc;
  logic        r_kill;

  logic        w_valid;
  logic        w_pop;
  logic        w_push;
  logic [2:0]  w_occupancy;
  logic        w_issue;

  // Words held after this edge's pop, plus the read already on its way back.
  assign w_valid     = (r_count != 2'd0);
  assign w_pop       = accept_in & w_valid;
  assign w_push      = r_inflight & ~r_kill & ~redirect_in;
  assign w_occupancy = {1'b0, r_count} - {2'b00, w_pop} + {2'b00, r_inflight};
  assign w_issue     = (r_state != S_RESET) & ~redirect_in & (w_occupancy < 3'd2);

  assign imem_rd   = w_issue;
  assign imem_addr = r_fetch_pc;
  assign valid_out = w_valid;
  assign IR_out    = w_valid ? r_q_ir0 : NOP_IR;
  assign PC_out    = w_valid ? r_q_pc0 : 8'h00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_RESET;
      r_fetch_pc    <= RESET_PC;
      r_q_ir0       <= NOP_IR;
      r_q_ir1       <= NOP_IR;
      r_q_pc0       <= 8'h00;
      r_q_pc1       <= 8'h00;
      r_count       <= 2'd0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 8'h00;
      r_kill        <= 1'b0;
    end else if (redirect_in) begin
      // The in-flight word lands in this very cycle and is simply not pushed.
      r_state    <= S_REFILL;
      r_fetch_pc <= redirect_pc;
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
      r_kill     <= r_inflight;
    end else begin
      // Any stale response has been dropped by now, so kill never outlives one cycle.
      r_kill     <= 1'b0;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + 8'd1;
      end

      if (w_pop && w_push) begin
        if (r_count == 2'd2) begin
          r_q_ir0 <= r_q_ir1;
          r_q_pc0 <= r_q_pc1;
          r_q_ir1 <= imem_rdata;
          r_q_pc1 <= r_inflight_pc;
        end else begin
          r_q_ir0 <= imem_rdata;
          r_q_pc0 <= r_inflight_pc;
        end
      end else if (w_pop) begin
        r_q_ir0 <= r_q_ir1;
        r_q_pc0 <= r_q_pc1;
      end else if (w_push) begin
        if (r_count == 2'd0) begin
          r_q_ir0 <= imem_rdata;
          r_q_pc0 <= r_inflight_pc;
        end else begin
          r_q_ir1 <= imem_rdata;
          r_q_pc1 <= r_inflight_pc;
        end
      end

      r_count <= r_count - {1'b0, w_pop} + {1'b0, w_push};

      case (r_state)
        S_RESET:  r_state <= S_RUN;
        S_REFILL: if (w_push) r_state <= S_RUN;
        default:  r_state <= S_RUN;
      endcase
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(w_push && !w_pop && (r_count == 2'd2)))
        else $error("fetch queue overflow: push into full queue");
    end
  end

endmodule
